cache_mem_responder: RTL and testbench

//  Responder (memory side) of the cache's rd_*/ret_*/wr_* refill/writeback interface.

---
 rtl/cache_mem_responder.sv | 180 ++++++++++++++++++
 tb/tb_cache_mem_responder.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/cache_mem_responder.sv
// Memory-side responder for the cache rd_*/ret_*/wr_* refill and writeback interface.
// Optional feature macro: CACHE_MEM_RAND_LAT_EN adds 0-3 LFSR-chosen wait cycles per request.
module cache_mem_responder #(
  parameter int MEM_WORDS_LOG2 = 10,
  parameter int RD_LAT         = 2,
  parameter int WR_LAT         = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         rd_req,
  input  logic [2:0]   rd_type,
  input  logic [31:0]  rd_addr,
  output logic         rd_rdy,
  output logic         ret_valid,
  output logic         ret_last,
  output logic [31:0]  ret_data,
  input  logic         wr_req,
  input  logic [2:0]   wr_type,
  input  logic [31:0]  wr_addr,
  input  logic [3:0]   wr_wstrb,
  input  logic [127:0] wr_data,
  output logic         wr_rdy,
  output logic         data_write_ok
);
  localparam int         AW        = MEM_WORDS_LOG2;
  localparam int         DEPTH     = 1 << AW;
  localparam logic [2:0] TYPE_LINE = 3'd4;

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_BEAT} rd_state_t;
  typedef enum logic       {W_IDLE, W_WAIT}         wr_state_t;

  rd_state_t rd_state, rd_state_nx;
  wr_state_t wr_state, wr_state_nx;

  logic [31:0]   mem [DEPTH];

  logic          rd_line_q;
  logic [AW-1:0] rd_word_q;
  logic [7:0]    rd_cnt, rd_lim;
  logic [1:0]    rd_beat, rd_beat_nx;
  logic [AW-1:0] rd_word_nx;
  logic          rd_last_nx, rd_accept, rd_hazard, rd_wait_done, rd_final;

  logic          wr_line_q;
  logic [AW-1:0] wr_word_q;
  logic [3:0]    wr_strb_q;
  logic [127:0]  wr_data_q;
  logic [7:0]    wr_cnt, wr_lim;
  logic          wr_accept, wr_done;

  logic          unused_addr_bits;
  assign unused_addr_bits = ^{rd_addr[31:AW+2], rd_addr[1:0], wr_addr[31:AW+2], wr_addr[1:0]};

  assign rd_accept    = (rd_state == R_IDLE) && rd_req;
  assign wr_accept    = (wr_state == W_IDLE) && wr_req;
  // A pending write to the same line holds the read so it returns post-write data.
  assign rd_hazard    = (wr_state == W_WAIT) && (wr_word_q[AW-1:2] == rd_word_q[AW-1:2]);
  assign rd_wait_done = (rd_state == R_WAIT) && (rd_cnt >= rd_lim) && !rd_hazard;
  assign rd_final     = (rd_state == R_BEAT) && (!rd_line_q || rd_beat == 2'd3);
  assign wr_done      = (wr_state == W_WAIT) && (wr_cnt >= wr_lim);

`ifdef CACHE_MEM_RAND_LAT_EN
  logic [2:0] lfsr;
  logic [1:0] rd_extra, wr_extra;

  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr     <= 3'b001;
      rd_extra <= 2'd0;
      wr_extra <= 2'd0;
    end else begin
      lfsr <= {lfsr[1:0], lfsr[2] ^ lfsr[1]};
      if (rd_accept) rd_extra <= lfsr[1:0];
      if (wr_accept) wr_extra <= lfsr[1:0];
    end
  end

  assign rd_lim = 8'(RD_LAT - 1) + {6'd0, rd_extra};
  assign wr_lim = 8'(WR_LAT - 1) + {6'd0, wr_extra};
`else
  assign rd_lim = 8'(RD_LAT - 1);
  assign wr_lim = 8'(WR_LAT - 1);
`endif

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    rd_state_nx = rd_state;
    unique case (rd_state)
      R_IDLE:  if (rd_req)       rd_state_nx = R_WAIT;
      R_WAIT:  if (rd_wait_done) rd_state_nx = R_BEAT;
      R_BEAT:  if (rd_final)     rd_state_nx = R_IDLE;
      default:                   rd_state_nx = R_IDLE;
    endcase
  end

  always_comb begin
    rd_beat_nx = (rd_state == R_BEAT) ? rd_beat + 2'd1 : 2'd0;
    rd_last_nx = !rd_line_q || (rd_beat_nx == 2'd3);
    rd_word_nx = rd_line_q ? {rd_word_q[AW-1:2], rd_beat_nx} : rd_word_q;
  end

  always_comb begin
    wr_state_nx = wr_state;
    unique case (wr_state)
      W_IDLE:  if (wr_req)  wr_state_nx = W_WAIT;
      W_WAIT:  if (wr_done) wr_state_nx = W_IDLE;
      default:              wr_state_nx = W_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_state  <= R_IDLE;
      rd_line_q <= 1'b0;
      rd_word_q <= '0;
      rd_cnt    <= 8'd0;
      rd_beat   <= 2'd0;
      rd_rdy    <= 1'b0;
      ret_valid <= 1'b0;
      ret_last  <= 1'b0;
      ret_data  <= 32'd0;
    end else begin
      rd_state <= rd_state_nx;
      rd_rdy   <= rd_accept;
      if (rd_accept) begin
        rd_line_q <= (rd_type == TYPE_LINE);
        rd_word_q <= rd_addr[AW+1:2];
        rd_cnt    <= 8'd0;
      end else if (rd_state == R_WAIT && rd_cnt < rd_lim) begin
        rd_cnt <= rd_cnt + 8'd1;
      end
      rd_beat   <= rd_beat_nx;
      ret_valid <= (rd_state_nx == R_BEAT);
      ret_last  <= (rd_state_nx == R_BEAT) && rd_last_nx;
      ret_data  <= (rd_state_nx == R_BEAT) ? mem[rd_word_nx] : 32'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_state      <= W_IDLE;
      wr_line_q     <= 1'b0;
      wr_word_q     <= '0;
      wr_strb_q     <= 4'd0;
      wr_data_q     <= '0;
      wr_cnt        <= 8'd0;
      wr_rdy        <= 1'b0;
      data_write_ok <= 1'b0;
    end else begin
      wr_state      <= wr_state_nx;
      wr_rdy        <= wr_accept;
      data_write_ok <= wr_done;
      if (wr_accept) begin
        wr_line_q <= (wr_type == TYPE_LINE);
        wr_word_q <= wr_addr[AW+1:2];
        wr_strb_q <= wr_wstrb;
        wr_data_q <= wr_data;
        wr_cnt    <= 8'd0;
      end else if (wr_state == W_WAIT && wr_cnt < wr_lim) begin
        wr_cnt <= wr_cnt + 8'd1;
      end
    end
  end

  // NOTE: the array has no reset; contents survive reset and only the FSMs restart.
  always_ff @(posedge clk) begin
    if (!reset && wr_done) begin
      if (wr_line_q) begin
        for (int k = 0; k < 4; k++) begin
          mem[{wr_word_q[AW-1:2], 2'(k)}] <= wr_data_q[32*k +: 32];
        end
      end else begin
        for (int b = 0; b < 4; b++) begin
          if (wr_strb_q[b]) mem[wr_word_q][8*b +: 8] <= wr_data_q[8*b +: 8];
        end
      end
    end
  end
endmodule

// File: tb/tb_cache_mem_responder.sv
// Scoreboard bench for cache_mem_responder: stimulus pushes expected acks/beats, a monitor pops and compares.
module tb_cache_mem_responder;
  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         rd_req = 1'b0;
  logic [2:0]   rd_type = 3'd0;
  logic [31:0]  rd_addr = 32'd0;
  logic         rd_rdy, ret_valid, ret_last;
  logic [31:0]  ret_data;
  logic         wr_req = 1'b0;
  logic [2:0]   wr_type = 3'd0;
  logic [31:0]  wr_addr = 32'd0;
  logic [3:0]   wr_wstrb = 4'd0;
  logic [127:0] wr_data = '0;
  logic         wr_rdy, data_write_ok;

  cache_mem_responder #(.MEM_WORDS_LOG2(10), .RD_LAT(2), .WR_LAT(3)) dut (
    .clk(clk), .reset(reset),
    .rd_req(rd_req), .rd_type(rd_type), .rd_addr(rd_addr), .rd_rdy(rd_rdy),
    .ret_valid(ret_valid), .ret_last(ret_last), .ret_data(ret_data),
    .wr_req(wr_req), .wr_type(wr_type), .wr_addr(wr_addr), .wr_wstrb(wr_wstrb),
    .wr_data(wr_data), .wr_rdy(wr_rdy), .data_write_ok(data_write_ok)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] data;
    logic        last;
    int          min_c;
    int          max_c;
  } beat_t;

  beat_t beat_q[$];
  int    rdy_q[$];
  int    wrdy_q[$];
  int    wok_q[$];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: every DUT event is matched against the oldest expectation of its kind.
  beat_t b;
  always @(negedge clk) begin
    if (rd_rdy === 1'b1) begin
      if (rdy_q.size() == 0) check("rd_rdy_spurious", 64'(rd_rdy), 64'd0);
      else check("rd_rdy_cycle", 64'(cyc), 64'(rdy_q.pop_front()));
    end
    if (wr_rdy === 1'b1) begin
      if (wrdy_q.size() == 0) check("wr_rdy_spurious", 64'(wr_rdy), 64'd0);
      else check("wr_rdy_cycle", 64'(cyc), 64'(wrdy_q.pop_front()));
    end
    if (data_write_ok === 1'b1) begin
      if (wok_q.size() == 0) check("write_ok_spurious", 64'(data_write_ok), 64'd0);
      else check("write_ok_cycle", 64'(cyc), 64'(wok_q.pop_front()));
    end
    if (ret_valid === 1'b1) begin
      if (beat_q.size() == 0) begin
        check("ret_spurious", 64'(ret_valid), 64'd0);
      end else begin
        b = beat_q.pop_front();
        check("ret_data", 64'(ret_data), 64'(b.data));
        check("ret_last", 64'(ret_last), 64'(b.last));
        if (b.min_c == b.max_c) check("ret_cycle", 64'(cyc), 64'(b.min_c));
        else check("ret_cycle_window", 64'(cyc >= b.min_c && cyc <= b.max_c), 64'd1);
      end
    end else if (ret_valid === 1'b0 && (ret_data !== 32'd0 || ret_last !== 1'b0)) begin
      check("ret_idle_quiet", {31'd0, ret_last, ret_data}, 64'd0);
    end
  end

  // Drives a request in the current cycle (caller sits just after a rising edge) and returns
  // one cycle later, so back-to-back calls issue in consecutive cycles.
  task automatic start_req(input bit do_rd, input logic [2:0] rt, input logic [31:0] ra,
                           input bit do_wr, input logic [2:0] wt, input logic [31:0] wa,
                           input logic [3:0] ws, input logic [127:0] wd, output int t);
    t        = cyc;
    rd_req   = do_rd;  rd_type = rt; rd_addr = ra;
    wr_req   = do_wr;  wr_type = wt; wr_addr = wa; wr_wstrb = ws; wr_data = wd;
    if (do_rd) rdy_q.push_back(t + 1);
    if (do_wr) begin
      wrdy_q.push_back(t + 1);
      wok_q.push_back(t + 4);
    end
    @(posedge clk); #1;
    rd_req = 1'b0;
    wr_req = 1'b0;
  endtask

  task automatic push_beat(input logic [31:0] d, input logic l, input int mn, input int mx);
    beat_t e;
    e.data = d; e.last = l; e.min_c = mn; e.max_c = mx;
    beat_q.push_back(e);
  endtask

  task automatic push_line(input logic [127:0] line, input int first);
    for (int k = 0; k < 4; k++) push_beat(line[32*k +: 32], k == 3, first + k, first + k);
  endtask

  task automatic wait_idle();
    int left;
    left = 200;
    while ((beat_q.size() + rdy_q.size() + wrdy_q.size() + wok_q.size()) != 0 && left > 0) begin
      @(posedge clk); #1;
      left--;
    end
    if (left == 0) begin
      check("drain_timeout", 64'(beat_q.size() + rdy_q.size() + wrdy_q.size() + wok_q.size()), 64'd0);
      beat_q.delete(); rdy_q.delete(); wrdy_q.delete(); wok_q.delete();
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  localparam logic [127:0] LINE40  = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
  localparam logic [127:0] LINE40B = {32'h44444444, 32'h33333333, 32'h22AB2222, 32'h11111111};
  localparam logic [127:0] LINE80  = {32'hC3C3C3C3, 32'hC2C2C2C2, 32'hC1C1C1C1, 32'hC0C0C0C0};
  localparam logic [127:0] LINE100 = {32'hA3A3A3A3, 32'hA2A2A2A2, 32'hA1A1A1A1, 32'hA0A0A0A0};

  initial begin
    int t, u;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {27'd0, rd_rdy, ret_valid, ret_last, wr_rdy, data_write_ok, ret_data}, 64'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Line write then line read at 0x40: acks T+1 / U+1, commit T+4, beats U+3..U+6.
    start_req(0, 3'd0, 32'd0, 1, 3'd4, 32'h40, 4'h0, LINE40, t);
    wait_idle();
    start_req(1, 3'd4, 32'h40, 0, 3'd0, 32'd0, 4'h0, '0, u);
    push_line(LINE40, u + 3);
    wait_idle();

    // Single-lane byte write merges into word 0x44.
    start_req(0, 3'd0, 32'd0, 1, 3'd0, 32'h44, 4'b0100, 128'h00AB0000, t);
    wait_idle();
    start_req(1, 3'd2, 32'h44, 0, 3'd0, 32'd0, 4'h0, '0, u);
    push_beat(32'h22AB2222, 1'b1, u + 3, u + 3);
    wait_idle();

    // Read of a line with a pending write waits until after the commit (commit at t+4).
    start_req(0, 3'd0, 32'd0, 1, 3'd4, 32'h80, 4'h0, LINE80, t);
    start_req(1, 3'd4, 32'h80, 0, 3'd0, 32'd0, 4'h0, '0, u);
    for (int k = 0; k < 4; k++) push_beat(LINE80[32*k +: 32], k == 3, t + 5 + k, t + 13 + k);
    wait_idle();

    // Simultaneous read and write to different lines are both acked in the same cycle.
    start_req(0, 3'd0, 32'd0, 1, 3'd4, 32'h100, 4'h0, LINE100, t);
    wait_idle();
    start_req(1, 3'd4, 32'h100, 1, 3'd2, 32'h200, 4'hF, 128'hDEADBEEF, t);
    push_line(LINE100, t + 3);
    wait_idle();
    start_req(1, 3'd2, 32'h200, 0, 3'd0, 32'd0, 4'h0, '0, u);
    push_beat(32'hDEADBEEF, 1'b1, u + 3, u + 3);
    wait_idle();

    // Reset during the second beat cancels the rest of the burst; array contents survive.
    start_req(1, 3'd4, 32'h40, 0, 3'd0, 32'd0, 4'h0, '0, u);
    push_beat(32'h11111111, 1'b0, u + 3, u + 3);
    push_beat(32'h22AB2222, 1'b0, u + 4, u + 4);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    check("reset_kills_beat", 64'(ret_valid), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    start_req(1, 3'd4, 32'h40, 0, 3'd0, 32'd0, 4'h0, '0, u);
    push_line(LINE40B, u + 3);
    wait_idle();

    // Upper address bits alias: 0x1040 maps to word 0x40.
    start_req(1, 3'd2, 32'h0000_1040, 0, 3'd0, 32'd0, 4'h0, '0, u);
    push_beat(32'h11111111, 1'b1, u + 3, u + 3);
    wait_idle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d expected completion", cyc);
    $fatal(1, "watchdog expired");
  end
endmodule
